ripple_count_sampler: RTL and testbench

//  Downstream consumer of the 4-bit ripple counter output. Resynchronises the asynchronous,
//  bit-skewed count into the clk domain and filters ripple transients. Presents each settled

---
 rtl/ripple_count_sampler.sv | 151 +++++++++++++++
 tb/tb_ripple_count_sampler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler
// Resynchronises an asynchronous, bit-skewed ripple counter value into clk,
// rejects ripple transients and reports each settled value with a one-cycle
// strobe. It also keeps a saturating wrap counter and a sticky sequence-error flag.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | not tracking; outputs hold, strobes low
// ST_SETTLE| waiting for the first stable sample; loaded without checks
// ST_TRACK | reporting each new stable value, checking wrap / +1 sequence

module ripple_count_sampler #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WRAP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              sample_en,
    output logic [WIDTH-1:0]  cnt_out,
    output logic              cnt_valid,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              glitch_err
);

    // Down-counter that blocks "stable" until the synchroniser and s_prev hold
    // real post-reset samples, so reset zeros are never reported as a count.
    localparam int                FILL_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [FILL_W-1:0] FILL_INIT = FILL_W'(SYNC_STAGES + 1);
    localparam logic [WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [WRAP_W-1:0] WRAP_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_TRACK  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  s_prev_q, s_prev_d;
    logic [FILL_W-1:0]                 fill_q, fill_d;
    logic [WIDTH-1:0]                  s_cur;
    logic                              stable;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  cnt_out_q, cnt_out_d;
    logic              cnt_valid_q, cnt_valid_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
    logic              glitch_err_q, glitch_err_d;
    logic [WIDTH-1:0]  cnt_succ;

    assign s_cur    = sync_q[SYNC_STAGES-1];
    assign stable   = (fill_q == '0) && (s_cur == s_prev_q);
    assign cnt_succ = cnt_out_q + WIDTH'(1);

    // Next value of the synchroniser chain, previous-sample register and fill timer.
    always_comb begin
        sync_d    = '0;
        sync_d[0] = cnt_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        s_prev_d = s_cur;
        fill_d   = (fill_q == '0) ? fill_q : fill_q - FILL_W'(1);
    end

    // Synchroniser chain, previous-sample register and fill timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            s_prev_q <= '0;
            fill_q   <= FILL_INIT;
        end else begin
            sync_q   <= sync_d;
            s_prev_q <= s_prev_d;
            fill_q   <= fill_d;
        end
    end

    // FSM next-state and output decisions; dropping sample_en overrides any update.
    always_comb begin
        state_d      = state_q;
        cnt_out_d    = cnt_out_q;
        cnt_valid_d  = 1'b0;
        wrap_pulse_d = 1'b0;
        wrap_count_d = wrap_count_q;
        glitch_err_d = glitch_err_q;
        if (!sample_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (stable) begin
                        cnt_out_d   = s_cur;
                        cnt_valid_d = 1'b1;
                        state_d     = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (stable && (s_cur != cnt_out_q)) begin
                        cnt_out_d   = s_cur;
                        cnt_valid_d = 1'b1;
                        if ((cnt_out_q == CNT_MAX) && (s_cur == '0)) begin
                            wrap_pulse_d = 1'b1;
                            if (wrap_count_q != WRAP_MAX) begin
                                wrap_count_d = wrap_count_q + WRAP_W'(1);
                            end
                        end else if (s_cur != cnt_succ) begin
                            glitch_err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_out_q    <= '0;
            cnt_valid_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
            glitch_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_out_q    <= cnt_out_d;
            cnt_valid_q  <= cnt_valid_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_count_q <= wrap_count_d;
            glitch_err_q <= glitch_err_d;
        end
    end

    assign cnt_out    = cnt_out_q;
    assign cnt_valid  = cnt_valid_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign glitch_err = glitch_err_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Testbench for ripple_count_sampler: directed steps plus randomized count
// sequences, compared against a value-level model of the reporting rules.

module tb_ripple_count_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cnt_in;
    logic       sample_en;
    logic [3:0] cnt_out;
    logic       cnt_valid;
    logic       wrap_pulse;
    logic [7:0] wrap_count;
    logic       glitch_err;

    int n_pass   = 0;
    int n_checks = 0;
    int n_valid  = 0;
    int n_wrap   = 0;

    // Reference model state: last reported value, total wraps, sticky error.
    logic [3:0] m_out    = 4'd0;
    int         m_wraps  = 0;
    logic       m_glitch = 1'b0;

    ripple_count_sampler #(.WIDTH(4), .SYNC_STAGES(2), .WRAP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .sample_en (sample_en),
        .cnt_out   (cnt_out),
        .cnt_valid (cnt_valid),
        .wrap_pulse(wrap_pulse),
        .wrap_count(wrap_count),
        .glitch_err(glitch_err)
    );

    always #5 clk = ~clk;

    // Count strobes on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (cnt_valid === 1'b1) n_valid++;
        if (wrap_pulse === 1'b1) n_wrap++;
    end

    function automatic int sat_wraps(input int w);
        return (w > 255) ? 255 : w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Present value v for n clocks, optionally preceded by a one-clock ripple
    // transient, then compare strobes seen in the window and outputs with the model.
    task automatic step(input logic [3:0] v, input int n, input bit use_tr, input logic [3:0] tr);
        int ev;
        int ew;
        ev = 0;
        ew = 0;
        n_valid = 0;
        n_wrap  = 0;
        if (use_tr) begin
            cnt_in = tr;
            @(posedge clk);
            #1;
        end
        cnt_in = v;
        repeat (n) @(posedge clk);
        #1;
        if (v != m_out) begin
            ev = 1;
            if (m_out == 4'd15 && v == 4'd0) begin
                ew = 1;
                m_wraps++;
            end else if (v != 4'(m_out + 1)) begin
                m_glitch = 1'b1;
            end
            m_out = v;
        end
        chk("valid_strobes", n_valid, ev);
        chk("wrap_strobes", n_wrap, ew);
        chk("cnt_out", cnt_out, m_out);
        chk("wrap_count", wrap_count, sat_wraps(m_wraps));
        chk("glitch_err", glitch_err, m_glitch);
    endtask

    initial begin
        logic [3:0] nxt;
        logic [3:0] tr;
        bit         use_tr;
        int         guard;

        // 1: reset held with live inputs
        rst = 1'b1;
        cnt_in = 4'd5;
        sample_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt_out", cnt_out, 0);
        chk("rst_cnt_valid", cnt_valid, 0);
        chk("rst_wrap_pulse", wrap_pulse, 0);
        chk("rst_wrap_count", wrap_count, 0);
        chk("rst_glitch_err", glitch_err, 0);

        // 2: first value reported exactly on the 4th edge after it is presented
        rst = 1'b0;
        cnt_in = 4'd3;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("first_valid_timing", cnt_valid, (i == 3) ? 1 : 0);
            chk("first_wrap_pulse", wrap_pulse, 0);
        end
        chk("first_cnt_out", cnt_out, 3);
        m_out = 4'd3;

        // 3: clean count 4..15,0,1
        for (int k = 4; k <= 17; k++) begin
            step(4'(k), 8, 1'b0, 4'd0);
        end
        chk("seq_wrap_count", wrap_count, 1);
        chk("seq_glitch_err", glitch_err, 0);

        // Random +1 counting with ripple transients and repeated holds
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                step(m_out, $urandom_range(5, 9), 1'b0, 4'd0);
            end else begin
                nxt = 4'(m_out + 1);
                tr = m_out & nxt;
                use_tr = (tr != m_out) && (tr != nxt) && ($urandom_range(0, 1) == 1);
                step(nxt, $urandom_range(5, 9), use_tr, tr);
            end
        end
        chk("rand_inc_glitch_err", glitch_err, 0);

        // 4: jump 4 -> 9 sets the sticky error without touching wrap_count
        guard = 0;
        while (m_out != 4'd4 && guard < 20) begin
            step(4'(m_out + 1), 6, 1'b0, 4'd0);
            guard++;
        end
        chk("reach_4", cnt_out, 4);
        step(4'd9, 8, 1'b0, 4'd0);
        chk("jump_glitch_err", glitch_err, 1);
        step(4'd10, 8, 1'b0, 4'd0);
        chk("glitch_sticky", glitch_err, 1);

        // 5: fast 6/7 toggling is never reported, the following hold of 7 is
        step(4'd6, 8, 1'b0, 4'd0);
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin
            cnt_in = (i % 2 == 0) ? 4'd7 : 4'd6;
            @(posedge clk);
            #1;
        end
        chk("toggle_no_valid", n_valid, 0);
        chk("toggle_cnt_out", cnt_out, 6);
        step(4'd7, 8, 1'b0, 4'd0);

        // Random jumps, transients and repeats
        for (int k = 0; k < 40; k++) begin
            nxt = 4'($urandom_range(0, 15));
            tr = 4'($urandom_range(0, 15));
            use_tr = ($urandom_range(0, 2) == 0);
            step(nxt, $urandom_range(5, 9), use_tr, tr);
        end

        // 6a: sample_en drops on the loading edge; re-entry loads without wrap check
        step(4'd15, 8, 1'b0, 4'd0);
        cnt_in = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        sample_en = 1'b0;
        n_valid = 0;
        n_wrap = 0;
        repeat (4) @(posedge clk);
        #1;
        cnt_in = 4'd11;
        repeat (4) @(posedge clk);
        #1;
        cnt_in = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_no_valid", n_valid, 0);
        chk("idle_cnt_out_hold", cnt_out, 15);
        chk("idle_wrap_count_hold", wrap_count, sat_wraps(m_wraps));
        sample_en = 1'b1;
        n_valid = 0;
        n_wrap = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("reenter_valid", n_valid, 1);
        chk("reenter_no_wrap", n_wrap, 0);
        chk("reenter_cnt_out", cnt_out, 0);
        chk("reenter_wrap_count", wrap_count, sat_wraps(m_wraps));
        chk("reenter_glitch_err", glitch_err, m_glitch);
        m_out = 4'd0;

        // 6b: 300 more wraps saturate the counter
        for (int k = 0; k < 300; k++) begin
            step(4'd15, 5, 1'b0, 4'd0);
            step(4'd0, 5, 1'b0, 4'd0);
        end
        chk("wrap_saturated", wrap_count, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
